gated_event_counter16: RTL and testbench

- Counts rising edges of an asynchronous event input during a programmable gate window of WIN clock cycles.
- Presents the 16-bit count on Q with a one-cycle valid strobe.
- Sits directly upstream of the 16-bit holding register (FD16CE-style, clocked on CK), which captures Q for the readout path.
- Also provides saturation, overflow flag and busy status for the sequencer.

---
 rtl/gated_event_counter16.sv | 126 ++++++++++++
 tb/tb_gated_event_counter16.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gated_event_counter16.sv
// Gated event counter: counts synchronised rising edges of EV over a WIN-cycle gate
// and presents a saturating result on Q with a one-cycle VLD strobe.
module gated_event_counter16 #(
    parameter int                WIDTH       = 16,
    parameter int                SYNC_STAGES = 2,
    // Count value loaded at gate start; nonzero only to reach saturation in short gates.
    parameter logic [WIDTH-1:0]  CNT_PRELOAD = '0
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             START,
    input  logic [WIDTH-1:0] WIN,
    input  logic             EV,
    output logic [WIDTH-1:0] Q,
    output logic             VLD,
    output logic             BUSY,
    output logic             OVF
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] REM_ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0] ev_sync;
    logic                   ev_prev;
    logic                   ev_rise;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic             sat, sat_n;
    logic [WIDTH-1:0] q_n;
    logic             ovf_n, vld_n, busy_n;

    // EV is fully asynchronous; ev_rise is a registered single-cycle edge pulse.
    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            ev_sync <= '0;
            ev_prev <= 1'b0;
            ev_rise <= 1'b0;
        end else begin
            ev_sync <= {ev_sync[SYNC_STAGES-2:0], EV};
            ev_prev <= ev_sync[SYNC_STAGES-1];
            ev_rise <= ev_sync[SYNC_STAGES-1] & ~ev_prev;
        end
    end

    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            sat   <= 1'b0;
            Q     <= '0;
            OVF   <= 1'b0;
            VLD   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rem   <= rem_n;
            sat   <= sat_n;
            Q     <= q_n;
            OVF   <= ovf_n;
            VLD   <= vld_n;
            BUSY  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem;
        sat_n   = sat;
        q_n     = Q;
        ovf_n   = OVF;
        vld_n   = 1'b0;
        busy_n  = BUSY;
        case (state)
            IDLE: begin
                if (START) begin
                    cnt_n  = CNT_PRELOAD;
                    sat_n  = 1'b0;
                    busy_n = 1'b1;
                    if (WIN != '0) begin
                        rem_n   = WIN;
                        state_n = COUNT;
                    end else begin
                        q_n     = '0;
                        ovf_n   = 1'b0;
                        vld_n   = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            COUNT: begin
                if (ev_rise) begin
                    if (cnt == CNT_MAX) sat_n = 1'b1;
                    else                cnt_n = cnt + 1'b1;
                end
                rem_n = rem - 1'b1;
                // Last sample of the gate: publish including this edge's event.
                if (rem == REM_ONE) begin
                    q_n     = cnt_n;
                    ovf_n   = sat_n;
                    vld_n   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gated_event_counter16.sv
// Bench for gated_event_counter16: directed gates plus random traffic, checked each cycle
// against a window-sum reference model over the recorded EV history.
module tb_gated_event_counter16;

    localparam int S    = 2;
    localparam int HMAX = 8192;

    logic        CK = 1'b0;
    logic        CLR, START, EV;
    logic [15:0] WIN;
    logic [15:0] q;
    logic        vld, busy, ovf;
    logic [3:0]  q4;
    logic        vld4, busy4, ovf4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit ev_hist [HMAX];
    int m_act [2], m_e0 [2], m_end [2], m_win [2], m_next [2], m_q [2];
    bit m_ovf [2], m_vld [2], m_busy [2];

    gated_event_counter16 #(.WIDTH(16), .SYNC_STAGES(S)) dut (
        .CK(CK), .CLR(CLR), .START(START), .WIN(WIN), .EV(EV),
        .Q(q), .VLD(vld), .BUSY(busy), .OVF(ovf)
    );

    gated_event_counter16 #(.WIDTH(4), .SYNC_STAGES(S), .CNT_PRELOAD(4'd12)) dut4 (
        .CK(CK), .CLR(CLR), .START(START), .WIN(WIN[3:0]), .EV(EV),
        .Q(q4), .VLD(vld4), .BUSY(busy4), .OVF(ovf4)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // An EV rise becomes countable SYNC+1 sampled edges after the level change.
    function automatic int rise_at(int n);
        if (n - S - 2 < 0) return 0;
        return (ev_hist[n-S-1] && !ev_hist[n-S-2]) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int wk, r, tot, mx, pre;
        ev_hist[cyc] = CLR ? 1'b0 : EV;
        for (int k = 0; k < 2; k++) begin
            if (CLR) begin
                m_act[k] = 0; m_next[k] = 0; m_q[k] = 0;
                m_ovf[k] = 0; m_vld[k] = 0; m_busy[k] = 0;
            end else begin
                wk  = (k == 0) ? int'(WIN) : int'(WIN[3:0]);
                mx  = (k == 0) ? 65535 : 15;
                pre = (k == 0) ? 0 : 12;
                if (m_act[k] != 0 && cyc > m_end[k]) m_act[k] = 0;
                if (START && cyc >= m_next[k]) begin
                    m_act[k]  = 1;
                    m_e0[k]   = cyc;
                    m_win[k]  = wk;
                    m_end[k]  = cyc + wk;
                    m_next[k] = cyc + wk + 2;
                end
                m_vld[k]  = (m_act[k] != 0) && (cyc == m_end[k]);
                m_busy[k] = (m_act[k] != 0);
                if (m_vld[k]) begin
                    if (m_win[k] == 0) begin
                        m_q[k] = 0; m_ovf[k] = 0;
                    end else begin
                        r = 0;
                        for (int n = m_e0[k] + 1; n <= m_end[k]; n++) r += rise_at(n);
                        tot      = pre + r;
                        m_q[k]   = (tot > mx) ? mx : tot;
                        m_ovf[k] = (tot > mx);
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic ev, input logic st, input logic [15:0] w);
        @(negedge CK);
        cyc++;
        if (cyc >= HMAX) begin
            $display("FAIL cycle budget exceeded at %0d", cyc);
            $fatal(1);
        end
        model_edge();
        chk("vld",   vld,   m_vld[0]);
        chk("busy",  busy,  m_busy[0]);
        chk("q",     q,     m_q[0]);
        chk("ovf",   ovf,   m_ovf[0]);
        chk("vld4",  vld4,  m_vld[1]);
        chk("busy4", busy4, m_busy[1]);
        chk("q4",    q4,    m_q[1]);
        chk("ovf4",  ovf4,  m_ovf[1]);
        EV = ev; START = st; WIN = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, WIN);
    endtask

    function automatic logic [63:0] mk(int a, int step, int n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[a + i*step] = 1'b1;
        return m;
    endfunction

    // One gate with START sampled at e0; rm marks the gate offsets at which a rise counts.
    task automatic gate_run(input string tag, input int win, input logic [63:0] rm, input int hi,
                            input int eq, input int eo, input int eq4, input int eo4);
        int c0, e0, off;
        logic lvl;
        c0 = cyc;
        e0 = c0 + 7;
        for (int i = 0; i < win + 12; i++) begin
            off = (c0 + i + 2) - e0;
            lvl = 1'b0;
            for (int r = 0; r < 64; r++)
                if (rm[r] && off >= r - 3 && off < r - 3 + hi) lvl = 1'b1;
            tick(lvl, i == 5, 16'(win));
            if (cyc == e0 - 1) chk({tag, ".busy_pre"}, busy, 0);
            if (cyc == e0 + win) begin
                chk({tag, ".vld"}, vld, 1);
                chk({tag, ".busy"}, busy, 1);
                chk({tag, ".q"}, q, eq);
                chk({tag, ".ovf"}, ovf, eo);
                if (eq4 >= 0) begin
                    chk({tag, ".vld4"}, vld4, 1);
                    chk({tag, ".q4"}, q4, eq4);
                    chk({tag, ".ovf4"}, ovf4, eo4);
                end
            end
            if (cyc == e0 + win + 1) begin
                chk({tag, ".vld_drop"}, vld, 0);
                chk({tag, ".busy_drop"}, busy, 0);
                chk({tag, ".q_hold"}, q, eq);
            end
        end
    endtask

    initial begin
        int c0, vc, hold;
        logic lv, st;
        logic [15:0] w;

        CLR = 1'b1; START = 1'b0; EV = 1'b0; WIN = '0;
        for (int i = 0; i < HMAX; i++) ev_hist[i] = 1'b0;
        idle(4);
        chk("rst.q", q, 0);
        chk("rst.vld", vld, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ovf", ovf, 0);
        #2 CLR = 1'b0;
        idle(6);

        gate_run("basic", 50, mk(1, 8, 7), 4, 7, 0, -1, -1);
        idle(6);

        // Abort a running gate with an async clear in the middle of a cycle.
        tick(1'b0, 1'b1, 16'd100);
        for (int i = 0; i < 30; i++) tick(1'((i / 3) % 2), 1'b0, 16'd100);
        #2 CLR = 1'b1;
        #1;
        chk("clr.q", q, 0);
        chk("clr.vld", vld, 0);
        chk("clr.busy", busy, 0);
        chk("clr.ovf", ovf, 0);
        chk("clr.q4", q4, 0);
        idle(4);
        #2 CLR = 1'b0;
        vc = 0;
        for (int i = 0; i < 120; i++) begin
            tick(1'b0, 1'b0, 16'd100);
            if (vld) vc++;
        end
        chk("clr.no_vld", vc, 0);

        gate_run("winA", 20, mk(0, 10, 3), 2, 2, 0, -1, -1);
        idle(4);
        gate_run("winB", 20, mk(1, 20, 2), 2, 1, 0, -1, -1);
        idle(4);
        gate_run("win0", 0, mk(0, 1, 1), 2, 0, 0, 0, 0);
        idle(4);
        gate_run("win1", 1, mk(1, 1, 1), 2, 1, 0, 13, 0);
        idle(4);
        gate_run("win1x", 1, mk(2, 1, 1), 2, 0, 0, 12, 0);
        idle(4);
        gate_run("sat", 15, mk(1, 4, 4), 2, 4, 0, 15, 1);
        idle(4);
        gate_run("unsat", 15, mk(1, 4, 3), 2, 3, 0, 15, 0);
        idle(20);

        // START held high: gates restart every WIN+2 cycles.
        vc = 0;
        c0 = cyc;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b1, 16'd10);
            if (vld) vc++;
            if (cyc == c0 + 13) chk("b2b.gap", busy, 0);
            if (cyc == c0 + 14) chk("b2b.restart", busy, 1);
        end
        chk("b2b.vld_count", vc, 3);
        idle(20);

        // START pulses during COUNT and DONE must not queue another gate.
        vc = 0;
        c0 = cyc;
        tick(1'b0, 1'b1, 16'd30);
        for (int i = 0; i < 40; i++) begin
            st = (i % 3 == 0) && (i <= 30);
            tick(1'((i / 3) % 2), st, 16'd30);
            if (vld) vc++;
        end
        chk("ign.vld_count", vc, 1);
        idle(10);

        hold = 0;
        lv = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                lv = ~lv;
                hold = int'($urandom_range(2, 6));
            end
            hold--;
            st = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       w = 16'd0;
                1:       w = 16'd1;
                2:       w = 16'd15;
                3:       w = 16'd16;
                default: w = 16'($urandom_range(2, 40));
            endcase
            tick(lv, st, w);
        end
        idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
